// File: rtl/mult_booth_pkg.sv
// Shared processor constants and the multiplier control-state encoding.
package mult_booth_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_booth.sv
// Radix-2 Booth signed multiplier: one add/sub-and-shift step per cycle,
// WIDTH steps per product, registered Hi/Lo and a one-cycle MultDone pulse.
module mult_booth
    import mult_booth_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultStart,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             MultDone
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_shift;
    logic [WIDTH-1:0] q_shift;
    logic             last_step;

    // The accumulator carries one extra bit so that subtracting -2^(WIDTH-1)
    // cannot overflow before the arithmetic shift.
    always_comb begin
        mcand_ext = {mcand[WIDTH-1], mcand};
        sum       = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + mcand_ext;
            2'b10:   sum = acc - mcand_ext;
            default: sum = acc;
        endcase
        acc_shift = {sum[WIDTH], sum[WIDTH:1]};
        q_shift   = {sum[0], q[WIDTH-1:1]};
        last_step = (count == CW'(WIDTH - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (MultStart) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand    <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            acc      <= '0;
            count    <= '0;
            Hi       <= '0;
            Lo       <= '0;
            MultDone <= 1'b0;
        end else begin
            MultDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (MultStart) begin
                        mcand <= A;
                        q     <= B;
                        q_m1  <= 1'b0;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= acc_shift;
                    q     <= q_shift;
                    q_m1  <= q[0];
                    count <= count + 1'b1;
                    // Only the final step publishes, so Hi/Lo never show partials.
                    if (last_step) begin
                        Hi       <= acc_shift[WIDTH-1:0];
                        Lo       <= q_shift;
                        MultDone <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed corner cases plus randomized
// operands compared against plain signed multiplication.
module tb_mult_booth;
    import mult_booth_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         MultStart;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic         MultDone;

    int             vectors     = 0;
    int             miscompares = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] prev_prod;

    mult_booth #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .MultStart (MultStart),
        .A         (A),
        .B         (B),
        .Hi        (Hi),
        .Lo        (Lo),
        .MultDone  (MultDone)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input bit scramble, input int poke_step, input string tag);
        logic [63:0] exp;
        int          n;
        bit          seen;
        exp_q.push_back(ref_prod(a, b));
        reset     = 1'b0;
        A         = a;
        B         = b;
        MultStart = 1'b1;
        @(posedge clk);
        #1 MultStart = 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == poke_step) begin
                MultStart = 1'b1;
                A = 32'd1;
                B = 32'd1;
            end else begin
                MultStart = 1'b0;
            end
            if (scramble) begin
                A = $urandom;
                B = $urandom;
            end
            if (MultDone) seen = 1;
            else check({tag, "_hold"}, {Hi, Lo}, prev_prod);
        end
        check({tag, "_latency"}, 64'(n), 64'(W));
        exp = exp_q.pop_front();
        check({tag, "_product"}, {Hi, Lo}, exp);
        prev_prod = exp;
        @(negedge clk);
        check({tag, "_pulse"}, 64'(MultDone), 64'd0);
    endtask

    initial begin
        int          pulses;
        int          c;
        int          last;
        int          first;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;

        reset     = 1'b1;
        MultStart = 1'b0;
        A         = '0;
        B         = '0;
        prev_prod = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(dut.state), 64'(IDLE));
        check("rst_hilo", {Hi, Lo}, 64'd0);
        check("rst_done", 64'(MultDone), 64'd0);

        run_mult(32'd3, 32'd4, 0, -1, "3x4");
        run_mult(32'hFFFF_FFF9, 32'd5, 0, -1, "m7x5");
        run_mult(32'h8000_0000, 32'h8000_0000, 0, -1, "minxmin");
        run_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, -1, "maxxmax");

        // A start request during CALC must be dropped, not queued.
        run_mult(32'd6, 32'd7, 0, 5, "ignore_start");
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (MultDone) pulses++;
        end
        check("no_second_pulse", 64'(pulses), 64'd0);

        // Reset in the middle of CALC abandons the operation.
        A         = 32'd9;
        B         = 32'd11;
        MultStart = 1'b1;
        @(posedge clk);
        #1 MultStart = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_state", 64'(dut.state), 64'(IDLE));
        check("rst_mid_hilo", {Hi, Lo}, 64'd0);
        check("rst_mid_done", 64'(MultDone), 64'd0);
        prev_prod = '0;
        run_mult(32'd2, 32'hFFFF_FFFE, 0, -1, "2xm2");

        // MultStart held high: one acceptance every W+2 cycles.
        ra        = $urandom;
        rb        = $urandom;
        exp       = ref_prod(ra, rb);
        A         = ra;
        B         = rb;
        MultStart = 1'b1;
        c         = 0;
        pulses    = 0;
        last      = 0;
        first     = 0;
        while (pulses < 3 && c < 200) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (MultDone) begin
                pulses++;
                check("b2b_product", {Hi, Lo}, exp);
                if (pulses == 1) first = c;
                else check("b2b_interval", 64'(c - last), 64'(W + 2));
                last = c;
                if (pulses == 3) MultStart = 1'b0;
                @(posedge clk);
                c++;
                @(negedge clk);
                check("b2b_width", 64'(MultDone), 64'd0);
            end
        end
        MultStart = 1'b0;
        check("b2b_count", 64'(pulses), 64'd3);
        check("b2b_first", 64'(first), 64'(W + 1));
        prev_prod = exp;

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: ra = 32'h0000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_mult(ra, rb, 1, -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port MultStart  input  1  request to start a multiplication; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  multiplicand, signed two's complement; sampled with MultStart.
REQ-006 SHALL have port B  input  WIDTH  multiplier, signed two's complement; sampled with MultStart.
REQ-007 SHALL have port Hi  output  WIDTH  upper half of the 2*WIDTH-bit signed product, registered.
REQ-008 SHALL have port Lo  output  WIDTH  lower half of the 2*WIDTH-bit signed product, registered.
REQ-009 SHALL have port MultDone  output  1  one-cycle pulse; Hi/Lo valid; drives Load of the downstream HI/LO registers.

Function
REQ-010 SHALL implement a radix-2 Booth signed multiplier with states IDLE, CALC and DONE.
REQ-011 SHALL, at an edge in IDLE with MultStart=1, load A and B into internal registers, clear the accumulator and Booth bit Q(-1), set the step counter to 0, and go to CALC.
REQ-012 SHALL, on each CALC edge, examine {Q0,Q(-1)}: 01 adds the multiplicand, 10 subtracts it, 00/11 does nothing; it SHALL then arithmetic-shift {acc,Q,Q(-1)} right by 1 and increment the counter.
REQ-013 SHALL hold the accumulator at WIDTH+1 bits so that a multiplicand of -2^(WIDTH-1) does not overflow.
REQ-014 SHALL perform exactly WIDTH CALC steps; on the edge that performs step WIDTH, it SHALL write Hi/Lo with the final product, set MultDone=1 and go to DONE.
REQ-015 SHALL therefore assert MultDone in the cycle after edge k+WIDTH, where k is the accepting edge (33rd cycle after acceptance for WIDTH=32).
REQ-016 SHALL assert MultDone for exactly one cycle, then return DONE->IDLE unconditionally on the next edge.
REQ-017 SHALL ignore MultStart in CALC and DONE, without queuing it; operands changing during CALC SHALL NOT affect the result.
REQ-018 SHALL hold Hi/Lo stable from completion until the next completion; intermediate values SHALL never appear on Hi/Lo.
REQ-019 SHALL accept MultStart on the first IDLE cycle after DONE, giving a minimum issue interval of WIDTH+2 cycles.
REQ-020 SHALL produce results identical to the mathematical signed product for all operand pairs, including both operands = -2^(WIDTH-1).

Reset
REQ-021 SHALL, when reset=1 at a posedge, force state IDLE and set Hi=0, Lo=0, MultDone=0, and clear the counter, accumulator and operand registers.
REQ-022 SHALL give reset priority over MultStart and over any CALC step; a reset mid-operation SHALL abandon it without a MultDone pulse.
REQ-023 SHALL accept MultStart on the first edge after reset deasserts.

Structure
REQ-024 SHALL take the state encoding (IDLE/CALC/DONE typedef) and the default width constant from the shared processor package.
REQ-025 SHALL be a single module with no sub-module; HI/LO holding downstream SHALL use the existing generic load-enable registrador instances, with Load tied to MultDone.

Verification
REQ-026 SHALL cover: A=3, B=4, MultStart for one cycle -> MultDone exactly 33 cycles later, Hi=0x00000000, Lo=0x0000000C.
REQ-027 SHALL cover: A=-7, B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFDD.
REQ-028 SHALL cover: A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000; and A=B=0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001.
REQ-029 SHALL cover: start 6x7, then reassert MultStart with A=B=1 at CALC step 5 -> single MultDone, Lo=0x0000002A, no second pulse.
REQ-030 SHALL cover: reset at CALC step 10 -> next cycle state IDLE, Hi=Lo=0, no MultDone; then 2x(-2) -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFC.
REQ-031 SHALL cover: back-to-back starts with MultStart held high -> accepted once per WIDTH+2 cycles, each MultDone a one-cycle pulse.
